// File: rtl/mod_counter_n.sv
// Purpose : parametrised modulo-N up/down counter with load, wrap/saturate, En prescaler and flags.
// Latency : 1 cycle; Q, Step, Tc and Ovf are registered, no combinational input-to-output path.
// Backpressure : none; En qualifies counting, the counter never stalls its inputs.
//
// Ports
//   Clk   rising-edge clock            Rst   async active-high reset
//   Clr   sync clear (highest prio)    Load  sync parallel load of D (clamped to MODULUS-1)
//   En    count enable                 Up    1 = increment, 0 = decrement
//   D     load value                   Sat   1 = saturate at boundary, 0 = wrap
//   Q     current count                Step  pulse: a count step was taken
//   Tc    pulse: step taken from the boundary value
//   Ovf   sticky: set by any boundary step, cleared by Clr/Rst
module mod_counter_n #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int PRESCALE = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Clr,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Sat,
  output logic [WIDTH-1:0] Q,
  output logic             Step,
  output logic             Tc,
  output logic             Ovf
);

  // Prescaler is at least one bit wide so PRESCALE=1 still has a legal vector.
  localparam int               PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] QMAX  = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pcnt;
  logic             step_now;
  logic             at_bound;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] d_clamped;

  always_comb begin
    // With PRESCALE=1, PLAST is 0 and pcnt never leaves 0, so every En edge steps.
    step_now = En && (pcnt == PLAST);
    at_bound = Up ? (Q == QMAX) : (Q == '0);

    q_step = Q;
    if (Up) begin
      if (at_bound) q_step = Sat ? Q : '0;
      else          q_step = Q + WIDTH'(1);
    end else begin
      if (at_bound) q_step = Sat ? Q : QMAX;
      else          q_step = Q - WIDTH'(1);
    end

    // MODULUS <= 2**WIDTH, so D >= MODULUS is equivalent to D > QMAX at WIDTH bits.
    d_clamped = (D > QMAX) ? QMAX : D;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Q    <= '0;
      pcnt <= '0;
      Step <= 1'b0;
      Tc   <= 1'b0;
      Ovf  <= 1'b0;
    end else if (Clr) begin
      Q    <= '0;
      pcnt <= '0;
      Step <= 1'b0;
      Tc   <= 1'b0;
      Ovf  <= 1'b0;
    end else if (Load) begin
      // Load restarts the prescaler phase; Ovf is deliberately preserved.
      Q    <= d_clamped;
      pcnt <= '0;
      Step <= 1'b0;
      Tc   <= 1'b0;
    end else if (En) begin
      if (step_now) begin
        pcnt <= '0;
        Q    <= q_step;
        Step <= 1'b1;
        Tc   <= at_bound;
        if (at_bound) Ovf <= 1'b1;
      end else begin
        pcnt <= pcnt + PW'(1);
        Step <= 1'b0;
        Tc   <= 1'b0;
      end
    end else begin
      Step <= 1'b0;
      Tc   <= 1'b0;
    end
  end

endmodule
